// File: rtl/hdlc_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hdlc_tx_arb                                                  |
// | Description : Round-robin arbiter and frame sequencer that shares one      |
// |               HDLC Tx datapath between NUM_REQ byte-stream frame sources.  |
// |               Moves bytes under a byte-level handshake, caps frame length, |
// |               converts requester aborts / overlong frames into a datapath  |
// |               abort, and enforces an idle gap between frames.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hdlc_tx_arb #(
   parameter int NUM_REQ    = 2,
   parameter int MAX_LEN    = 126,
   parameter int GAP_CYCLES = 16
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [NUM_REQ-1:0]   Req_Valid,
   input  logic [8*NUM_REQ-1:0] Req_Data,
   input  logic [NUM_REQ-1:0]   Req_Last,
   input  logic [NUM_REQ-1:0]   Req_Abort,
   output logic [NUM_REQ-1:0]   Req_Ready,
   output logic [NUM_REQ-1:0]   Grant,
   output logic [7:0]           Tx_Data,
   output logic                 Tx_WrByte,
   input  logic                 Tx_Done,
   output logic                 Tx_ValidFrame,
   output logic                 Tx_AbortFrame,
   input  logic                 Tx_AbortedTrans,
   output logic                 Err_Overlong,
   output logic                 Busy
);

   localparam int                 c_IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int                 c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [7:0]         c_MAX_CNT  = 8'(MAX_LEN);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);
   localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WAIT  = 3'd2,
      S_CLOSE = 3'd3,
      S_ABORT = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t               r_state;
   logic [c_IDX_W-1:0]   r_gidx;
   logic [c_IDX_W-1:0]   r_last_grant;
   logic [NUM_REQ-1:0]   r_grant;
   logic [7:0]           r_count;
   logic [c_GAP_W-1:0]   r_gap;
   logic                 r_tx_ready;
   logic [7:0]           r_tx_data;
   logic                 r_wrbyte;
   logic                 r_valid_frame;
   logic                 r_abort_frame;
   logic                 r_err_overlong;

   logic                 w_sel_any;
   logic [c_IDX_W-1:0]   w_sel_idx;
   logic [c_IDX_W-1:0]   w_cand;
   logic                 w_g_valid;
   logic                 w_g_last;
   logic                 w_g_abort;
   logic [7:0]           w_g_data;
   logic                 w_at_max;
   logic                 w_overlong;
   logic                 w_in_frame;
   logic                 w_abort;
   logic                 w_accept;
   logic [NUM_REQ-1:0]   w_gidx_onehot;
   logic [NUM_REQ-1:0]   w_sel_onehot;

   // Round-robin pick: the nearest valid requester after the last owner wins,
   // so the loop runs farthest-first and lets closer candidates overwrite.
   always_comb begin
      w_sel_any = 1'b0;
      w_sel_idx = '0;
      w_cand    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_cand = c_IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
         if (Req_Valid[w_cand]) begin
            w_sel_any = 1'b1;
            w_sel_idx = w_cand;
         end
      end
   end

   // One-hot decode of the current owner and of the arbitration winner.
   always_comb begin
      w_gidx_onehot = '0;
      w_sel_onehot  = '0;
      w_gidx_onehot[r_gidx]    = 1'b1;
      w_sel_onehot[w_sel_idx]  = 1'b1;
   end

   // Signals of the granted requester only; other requesters are invisible.
   assign w_g_valid = Req_Valid[r_gidx];
   assign w_g_last  = Req_Last[r_gidx];
   assign w_g_abort = Req_Abort[r_gidx];
   assign w_g_data  = Req_Data[{r_gidx, 3'b000} +: 8];

   // A non-final byte offered once MAX_LEN bytes are already in is overlong;
   // a final byte at that point is not an error but cannot be taken either.
   assign w_at_max   = (r_count == c_MAX_CNT);
   assign w_overlong = w_g_valid && !w_g_last && w_at_max;
   assign w_in_frame = (r_state == S_LOAD) || (r_state == S_WAIT);
   assign w_abort    = w_in_frame && (w_g_abort || w_overlong);
   assign w_accept   = (r_state == S_LOAD) && w_g_valid && r_tx_ready &&
                       !w_g_abort && !w_at_max;

   assign Req_Ready = w_accept ? w_gidx_onehot : '0;

   // Frame sequencer: arbitration, byte handshake, close/abort and idle gap.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_state        <= S_IDLE;
         r_gidx         <= '0;
         r_last_grant   <= c_LAST_IDX;
         r_grant        <= '0;
         r_count        <= 8'd0;
         r_gap          <= '0;
         r_tx_ready     <= 1'b1;
         r_tx_data      <= 8'd0;
         r_wrbyte       <= 1'b0;
         r_valid_frame  <= 1'b0;
         r_abort_frame  <= 1'b0;
         r_err_overlong <= 1'b0;
      end else begin
         r_wrbyte       <= 1'b0;
         r_abort_frame  <= 1'b0;
         r_err_overlong <= 1'b0;

         // Datapath is busy from the write strobe until it reports Done.
         if (w_accept) begin
            r_tx_ready <= 1'b0;
         end else if (Tx_Done) begin
            r_tx_ready <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_sel_any) begin
                  r_gidx        <= w_sel_idx;
                  r_grant       <= w_sel_onehot;
                  r_valid_frame <= 1'b1;
                  r_count       <= 8'd0;
                  r_state       <= S_LOAD;
               end
            end

            S_LOAD: begin
               if (w_abort) begin
                  r_abort_frame  <= 1'b1;
                  r_valid_frame  <= 1'b0;
                  r_err_overlong <= w_overlong && !w_g_abort;
                  r_state        <= S_ABORT;
               end else if (w_accept) begin
                  r_wrbyte  <= 1'b1;
                  r_tx_data <= w_g_data;
                  if (r_count != 8'hFF) begin
                     r_count <= r_count + 8'd1;
                  end
                  r_state <= w_g_last ? S_CLOSE : S_WAIT;
               end
            end

            S_WAIT: begin
               if (w_abort) begin
                  r_abort_frame  <= 1'b1;
                  r_valid_frame  <= 1'b0;
                  r_err_overlong <= w_overlong && !w_g_abort;
                  r_state        <= S_ABORT;
               end else if (Tx_Done) begin
                  r_state <= S_LOAD;
               end
            end

            S_CLOSE: begin
               if (Tx_Done) begin
                  r_valid_frame <= 1'b0;
                  r_last_grant  <= r_gidx;
                  r_grant       <= '0;
                  r_gap         <= c_GAP_LOAD;
                  r_state       <= S_GAP;
               end
            end

            S_ABORT: begin
               if (Tx_AbortedTrans) begin
                  r_last_grant <= r_gidx;
                  r_grant      <= '0;
                  r_gap        <= c_GAP_LOAD;
                  r_state      <= S_GAP;
               end
            end

            S_GAP: begin
               if (r_gap == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gap <= r_gap - 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign Grant         = r_grant;
   assign Tx_Data       = r_tx_data;
   assign Tx_WrByte     = r_wrbyte;
   assign Tx_ValidFrame = r_valid_frame;
   assign Tx_AbortFrame = r_abort_frame;
   assign Err_Overlong  = r_err_overlong;
   assign Busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hdlc_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hdlc_tx_arb                                               |
// | Description : Randomized self-checking bench for hdlc_tx_arb. Requesters   |
// |               stream random frames (normal, overlong, max-length, aborted, |
// |               abort-with-last); a transaction-level model predicts grant   |
// |               order, written bytes, frame end, aborts and gap timing.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hdlc_tx_arb;

   localparam int NR   = 3;
   localparam int MAXL = 126;
   localparam int GAP  = 4;
   localparam int NCYC = 16000;

   logic              Clk;
   logic              Rst;
   logic [NR-1:0]     Req_Valid;
   logic [8*NR-1:0]   Req_Data;
   logic [NR-1:0]     Req_Last;
   logic [NR-1:0]     Req_Abort;
   logic [NR-1:0]     Req_Ready;
   logic [NR-1:0]     Grant;
   logic [7:0]        Tx_Data;
   logic              Tx_WrByte;
   logic              Tx_Done;
   logic              Tx_ValidFrame;
   logic              Tx_AbortFrame;
   logic              Tx_AbortedTrans;
   logic              Err_Overlong;
   logic              Busy;

   hdlc_tx_arb #(
      .NUM_REQ    (NR),
      .MAX_LEN    (MAXL),
      .GAP_CYCLES (GAP)
   ) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .Req_Valid       (Req_Valid),
      .Req_Data        (Req_Data),
      .Req_Last        (Req_Last),
      .Req_Abort       (Req_Abort),
      .Req_Ready       (Req_Ready),
      .Grant           (Grant),
      .Tx_Data         (Tx_Data),
      .Tx_WrByte       (Tx_WrByte),
      .Tx_Done         (Tx_Done),
      .Tx_ValidFrame   (Tx_ValidFrame),
      .Tx_AbortFrame   (Tx_AbortFrame),
      .Tx_AbortedTrans (Tx_AbortedTrans),
      .Err_Overlong    (Err_Overlong),
      .Busy            (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int t_cyc    = 0;

   // Requester-side frame sources
   int          flen   [NR];
   int          fpos   [NR];
   int          fabort [NR];
   bit          flast  [NR];
   int          fcount [NR];
   logic [7:0]  fdata  [NR][128];

   // Transaction-level model: 0 = no frame, 1 = frame open, 2 = aborting
   int          m_phase, m_g, m_cnt, m_out, m_last, m_gap_end;
   bit          m_closing;
   logic [NR-1:0] m_rdy;
   bit          x_wr, x_ab, x_err;
   logic [7:0]  x_data;
   int          done_at, at_at;
   logic [NR-1:0] g_obs, rdy_obs;
   bit          rst_was;

   task automatic t_check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, t_cyc);
      end
   endtask

   function automatic int f_rr(input logic [NR-1:0] v, input int last);
      for (int k = 1; k <= NR; k++) begin
         if (v[(last + k) % NR]) return (last + k) % NR;
      end
      return 0;
   endfunction

   task automatic new_frame(input int i);
      int kind;
      kind = (fcount[i] < 5) ? fcount[i] : int'($urandom_range(0, 9));
      fcount[i]++;
      fpos[i]   = 0;
      fabort[i] = -1;
      flast[i]  = 1'b1;
      case (kind)
         0:       flen[i] = int'($urandom_range(1, 4));
         1: begin flen[i] = MAXL + 1; flast[i] = 1'b0; end
         2:       flen[i] = MAXL;
         3: begin flen[i] = int'($urandom_range(3, 6)); fabort[i] = 2; end
         4: begin flen[i] = int'($urandom_range(1, 4)); fabort[i] = flen[i] - 1; end
         9: begin flen[i] = int'($urandom_range(1, 6));
                  fabort[i] = int'($urandom_range(0, flen[i] - 1)); end
         default: flen[i] = int'($urandom_range(1, 6));
      endcase
      for (int b = 0; b < 128; b++) fdata[i][b] = 8'($urandom);
      if (i == 0 && fcount[i] == 1) begin
         flen[i] = 3; fabort[i] = -1; flast[i] = 1'b1;
         fdata[i][0] = 8'h7E; fdata[i][1] = 8'h01; fdata[i][2] = 8'hFF;
      end
   endtask

   task automatic m_reset(input int c);
      m_phase = 0; m_g = 0; m_cnt = 0; m_out = 0; m_closing = 1'b0;
      m_last = NR - 1; m_gap_end = c; done_at = -1; at_at = -1;
   endtask

   initial begin
      bit do_abort, do_err;
      Rst = 1'b0; Req_Valid = '0; Req_Data = '0; Req_Last = '0; Req_Abort = '0;
      Tx_Done = 1'b0; Tx_AbortedTrans = 1'b0;
      g_obs = '0; rdy_obs = '0;
      for (int i = 0; i < NR; i++) begin fcount[i] = 0; new_frame(i); end
      m_reset(0);

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         t_cyc = cyc;
         @(negedge Clk);
         Rst = !(cyc < 2 || (cyc >= 6000 && cyc < 6002) || cyc == 11000);
         Tx_Done = (done_at == cyc) ||
                   (done_at < 0 && m_out == 0 && $urandom_range(0, 99) < 3);
         Tx_AbortedTrans = (at_at == cyc);
         for (int i = 0; i < NR; i++) begin
            Req_Valid[i]      = ($urandom_range(0, 99) < 85);
            Req_Data[8*i +: 8] = fdata[i][fpos[i]];
            Req_Last[i]       = flast[i] && (fpos[i] == flen[i] - 1);
            Req_Abort[i]      = g_obs[i] ? (fpos[i] == fabort[i])
                                         : ($urandom_range(0, 99) < 3);
         end
         #1;
         // Acceptance rule of the open frame, evaluated on the driven inputs
         m_rdy = '0;
         if (m_phase == 1 && !m_closing && m_out == 0 && Req_Valid[m_g] &&
             !Req_Abort[m_g] && m_cnt < MAXL) m_rdy[m_g] = 1'b1;
         t_check("req_ready", 32'(Req_Ready), 32'(m_rdy));
         rdy_obs = Req_Ready;
         rst_was = Rst;

         x_wr = 1'b0; x_ab = 1'b0; x_err = 1'b0; x_data = 8'd0;
         do_abort = 1'b0; do_err = 1'b0;
         if (!Rst) begin
            m_reset(cyc);
         end else begin
            case (m_phase)
               0: if (cyc >= m_gap_end + 1 && Req_Valid != '0) begin
                     m_g = f_rr(Req_Valid, m_last);
                     m_phase = 1; m_cnt = 0; m_closing = 1'b0;
                  end
               1: if (m_closing) begin
                     if (Tx_Done) begin
                        m_phase = 0; m_last = m_g; m_gap_end = cyc + GAP;
                     end
                  end else if (Req_Abort[m_g]) begin
                     do_abort = 1'b1;
                  end else if (Req_Valid[m_g] && !Req_Last[m_g] && m_cnt == MAXL) begin
                     do_abort = 1'b1; do_err = 1'b1;
                  end else if (m_rdy[m_g]) begin
                     x_wr = 1'b1; x_data = Req_Data[8*m_g +: 8];
                     m_cnt++; m_closing = Req_Last[m_g];
                  end
               default: if (Tx_AbortedTrans) begin
                     m_phase = 0; m_last = m_g; m_gap_end = cyc + GAP;
                  end
            endcase
            if (Tx_Done && m_out > 0) m_out--;
            if (done_at == cyc) done_at = -1;
            if (at_at == cyc) at_at = -1;
            if (x_wr) begin
               m_out++;
               done_at = cyc + int'($urandom_range(1, 3));
            end
            if (do_abort) begin
               m_phase = 2; x_ab = 1'b1; x_err = do_err;
               at_at = cyc + int'($urandom_range(1, 5));
            end
         end

         @(posedge Clk);
         #1;
         t_check("grant", 32'(Grant), (m_phase != 0) ? (32'd1 << m_g) : 32'd0);
         t_check("valid_frame", 32'(Tx_ValidFrame), 32'(m_phase == 1));
         t_check("busy", 32'(Busy), 32'(m_phase != 0 || cyc < m_gap_end));
         t_check("wr_byte", 32'(Tx_WrByte), 32'(x_wr));
         if (x_wr) t_check("tx_data", 32'(Tx_Data), 32'(x_data));
         if (!rst_was) t_check("reset_data", 32'(Tx_Data), 32'd0);
         t_check("abort_frame", 32'(Tx_AbortFrame), 32'(x_ab));
         t_check("err_overlong", 32'(Err_Overlong), 32'(x_err));

         // Requesters react to what the DUT did at this edge
         for (int i = 0; i < NR; i++) begin
            if (!rst_was) begin
               fpos[i] = 0;
            end else if (rdy_obs[i]) begin
               fpos[i]++;
               if (fpos[i] == flen[i]) new_frame(i);
            end else if (Tx_AbortFrame && Grant[i]) begin
               new_frame(i);
            end
         end
         g_obs = Grant;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
